// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART packetizer:
//   - uart_state_t : transmitter FSM states
//   - PAR_*        : parity mode encodings for the PARITY parameter
//   - LINE_IDLE    : level of the UART line when no frame is in flight
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic LINE_IDLE = 1'b1;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy and flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty) and head-of-queue data;
//                dout shows the head word combinationally so the consumer
//                can capture it on the same edge that pops it
//   full       : DEPTH entries held
//   empty      : no entries held
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign w_do_push = push & ~r_full;
    assign w_do_pop  = pop  & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    // NOTE: storage is deliberately not reset; resetting the pointers and
    // count already discards the contents, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule : sync_fifo

// File: rtl/uart_packetizer_param.sv
// ---------------------------------------------------------------------------
// uart_packetizer_param
// Buffers parallel words in a FIFO and serialises them as UART frames
// (start, DATA_W bits LSB first, optional parity, STOP_BITS stop bits).
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_in     : word to enqueue
//   data_valid  : data_in valid this cycle
//   wr_en       : write enable; push = data_valid & wr_en & !fifo_full
//   tx_ready    : downstream permits a new frame (looked at only when a
//                 frame could start)
//   serial_out  : UART line, idles high
//   fifo_full   : FIFO holds FIFO_DEPTH entries
//   fifo_empty  : FIFO holds no entries
//   fifo_count  : FIFO occupancy
//   tx_busy     : high from first start-bit cycle to last stop-bit cycle
//   overflow    : one-cycle pulse after a write was dropped because full
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_packetizer_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        data_valid,
    input  logic                        wr_en,
    input  logic                        tx_ready,
    output logic                        serial_out,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_busy,
    output logic                        overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              ODD_INV   = (PARITY == PAR_ODD);
    localparam logic              HAS_PAR   = (PARITY != PAR_NONE);

    uart_state_t r_state;
    uart_state_t w_state_next;

    logic [BAUD_W-1:0] r_baud_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_stop_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_parity;
    logic              w_parity_next;
    logic              r_serial_out;
    logic              w_serial_next;
    logic              r_tx_busy;
    logic              w_busy_next;
    logic              r_overflow;

    logic [DATA_W-1:0]           w_fifo_dout;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_launch;
    logic                        w_bit_done;
    logic                        w_frame_end;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_push      = data_valid & wr_en & ~w_fifo_full;
    assign w_launch    = ~w_fifo_empty & tx_ready;
    assign w_bit_done  = (r_baud_cnt == '0);
    assign w_frame_end = (r_state == ST_STOP) & w_bit_done & (r_stop_cnt == STOP_LAST);
    // A frame starts from IDLE or straight out of the last stop-bit cycle.
    assign w_pop       = w_launch & ((r_state == ST_IDLE) | w_frame_end);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_launch)   w_state_next = ST_START;
            ST_START: if (w_bit_done) w_state_next = ST_DATA;
            ST_DATA:  if (w_bit_done && (r_bit_idx == IDX_LAST))
                          w_state_next = HAS_PAR ? ST_PAR : ST_STOP;
            ST_PAR:   if (w_bit_done) w_state_next = ST_STOP;
            ST_STOP:  if (w_frame_end) w_state_next = w_launch ? ST_START : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: values the registered outputs and shifter take on the
    // next edge, so the line level always matches the state being entered.
    always_comb begin
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        if (w_pop) begin
            w_shift_next  = w_fifo_dout;
            w_parity_next = (^w_fifo_dout) ^ ODD_INV;
        end else if ((r_state == ST_DATA) && w_bit_done) begin
            w_shift_next  = r_shift >> 1;
        end

        case (w_state_next)
            ST_START: w_serial_next = 1'b0;
            ST_DATA:  w_serial_next = w_shift_next[0];
            ST_PAR:   w_serial_next = w_parity_next;
            ST_STOP:  w_serial_next = 1'b1;
            default:  w_serial_next = LINE_IDLE;
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt   <= BAUD_LOAD;
            r_bit_idx    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_serial_out <= LINE_IDLE;
            r_tx_busy    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // The counter sits at its load value in IDLE so a launch gets a
            // full-length start bit.
            if ((r_state == ST_IDLE) || w_bit_done) r_baud_cnt <= BAUD_LOAD;
            else                                     r_baud_cnt <= r_baud_cnt - 1'b1;

            if ((r_state == ST_DATA) && w_bit_done)
                r_bit_idx <= (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + 1'b1;

            if ((r_state == ST_STOP) && w_bit_done)
                r_stop_cnt <= w_frame_end ? 1'b0 : 1'b1;

            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_serial_out <= w_serial_next;
            r_tx_busy    <= w_busy_next;
            r_overflow   <= data_valid & wr_en & w_fifo_full;
        end
    end

    assign serial_out = r_serial_out;
    assign tx_busy    = r_tx_busy;
    assign overflow   = r_overflow;
    assign fifo_full  = w_fifo_full;
    assign fifo_empty = w_fifo_empty;
    assign fifo_count = w_fifo_count;

endmodule : uart_packetizer_param

// File: tb/tb_uart_packetizer_param.sv
// ---------------------------------------------------------------------------
// tb_uart_packetizer_param
// Three instances share one stimulus stream, all at 4 clocks per bit:
//   u_main : 8N1, FIFO depth 4 (checked every cycle against a queue/timeline
//            model, plus a line decoder that recovers the sent words)
//   u_even : 8E2, depth 16
//   u_odd  : 8O2, depth 16
// ---------------------------------------------------------------------------
module tb_uart_packetizer_param;

    localparam int CPB   = 4;
    localparam int MDEP  = 4;
    localparam int MFRM  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       wr_en;
    logic       tx_ready;

    logic       m_serial, m_full, m_empty, m_busy, m_ovf;
    logic [2:0] m_count;
    logic       e_serial, e_full, e_empty, e_busy, e_ovf;
    logic [4:0] e_count;
    logic       o_serial, o_full, o_empty, o_busy, o_ovf;
    logic [4:0] o_count;

    always #5 clk = ~clk;

    uart_packetizer_param #(
        .DATA_W(8), .FIFO_DEPTH(MDEP), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .wr_en(wr_en), .tx_ready(tx_ready), .serial_out(m_serial),
        .fifo_full(m_full), .fifo_empty(m_empty), .fifo_count(m_count),
        .tx_busy(m_busy), .overflow(m_ovf)
    );

    uart_packetizer_param #(
        .DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)
    ) u_even (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .wr_en(wr_en), .tx_ready(tx_ready), .serial_out(e_serial),
        .fifo_full(e_full), .fifo_empty(e_empty), .fifo_count(e_count),
        .tx_busy(e_busy), .overflow(e_ovf)
    );

    uart_packetizer_param #(
        .DATA_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)
    ) u_odd (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .wr_en(wr_en), .tx_ready(tx_ready), .serial_out(o_serial),
        .fifo_full(o_full), .fifo_empty(o_empty), .fifo_count(o_count),
        .tx_busy(o_busy), .overflow(o_ovf)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for u_main: a word queue plus the timeline of the
    // frame in flight (cycles remaining, bit shown = elapsed / CPB).
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    int         m_rem;
    logic [9:0] m_bits;
    logic       m_ovf_exp;

    task automatic model_reset();
        mq.delete();
        m_rem     = 0;
        m_bits    = '1;
        m_ovf_exp = 1'b0;
    endtask

    task automatic model_step();
        bit launch;
        bit push_ok;
        launch    = (m_rem <= 1) && (mq.size() > 0) && tx_ready;
        push_ok   = data_valid && wr_en && (mq.size() < MDEP);
        m_ovf_exp = data_valid && wr_en && (mq.size() == MDEP);
        if (launch) begin
            m_bits = {1'b1, mq.pop_front(), 1'b0};
            m_rem  = MFRM;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (push_ok) mq.push_back(data_in);
    endtask

    task automatic check_main();
        logic exp_ser;
        exp_ser = (m_rem > 0) ? m_bits[(MFRM - m_rem) / CPB] : 1'b1;
        check("main serial_out", m_serial, exp_ser);
        check("main tx_busy",    m_busy,   m_rem > 0);
        check("main fifo_count", m_count,  mq.size());
        check("main fifo_full",  m_full,   mq.size() == MDEP);
        check("main fifo_empty", m_empty,  mq.size() == 0);
        check("main overflow",   m_ovf,    m_ovf_exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_main();
    endtask

    // ------------------------------------------------------------------
    // Independent line decoder for u_main: mid-bit sampling of 8N1.
    // ------------------------------------------------------------------
    logic [7:0] rx_q[$];
    logic       rx_active;
    int         rx_cnt;
    logic [7:0] rx_sh;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
        end else if (!rx_active) begin
            if (!m_serial) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
            end
        end else begin
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % CPB) == 2)
                rx_sh[(rx_cnt - 6) / CPB] <= m_serial;
            if (rx_cnt == 38 && m_serial) rx_q.push_back(rx_sh);
            if (rx_cnt == MFRM - 1) rx_active <= 1'b0;
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        data_valid = 1'b0;
        wr_en      = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check("rst main serial_out", m_serial, 1'b1);
        check("rst main fifo_empty", m_empty,  1'b1);
        check("rst main fifo_full",  m_full,   1'b0);
        check("rst main fifo_count", m_count,  0);
        check("rst main tx_busy",    m_busy,   1'b0);
        check("rst main overflow",   m_ovf,    1'b0);
        check("rst even serial/busy/empty/full/cnt/ovf",
              {e_serial, e_busy, e_empty, e_full, e_count, e_ovf}, {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0});
        check("rst odd serial/busy/empty/full/cnt/ovf",
              {o_serial, o_busy, o_empty, o_full, o_count, o_ovf}, {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0});
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       dv;
        logic       we;
        logic [7:0] data;
        int         cnt;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t tbl[9];
    int   exp_ac[10]   = '{0, 0, 0, 1, 1, 0, 1, 0, 1, 1};
    int   exp_even[12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int   exp_odd[12]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [7:0] sent4[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int base;
        int busy_cycles;
        int busy_falls;
        logic prev_busy;
        int rate;
        int rmode;

        rst_n      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        wr_en      = 1'b0;
        tx_ready   = 1'b0;
        model_reset();

        //                dv    we    data   cnt full  empty ovf
        tbl[0] = '{1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'hEE, 1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hEF, 1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h22, 2, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'h33, 3, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h44, 4, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h55, 4, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 8'h66, 4, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 8'h77, 4, 1'b1, 1'b0, 1'b0};

        // 1. Reset
        do_reset();

        // 2. Single 8N1 frame of 0xAC
        base = rx_q.size();
        tx_ready = 1'b1; data_in = 8'hAC; data_valid = 1'b1; wr_en = 1'b1;
        cycle();
        data_valid = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < MFRM; i++) begin
            cycle();
            check($sformatf("ac line cyc%0d", i), m_serial, exp_ac[i / CPB]);
            check($sformatf("ac busy cyc%0d", i), m_busy, 1'b1);
        end
        cycle();
        check("ac busy after frame", m_busy, 1'b0);
        check("ac count after frame", m_count, 0);
        check("ac decoded count", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("ac decoded word", rx_q[base], 8'hAC);

        // 3. Back-to-back frames, no tx_busy gap
        base = rx_q.size();
        busy_cycles = 0; busy_falls = 0; prev_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            data_valid = (i < 2); wr_en = (i < 2);
            data_in    = (i == 0) ? 8'hAC : 8'hCA;
            cycle();
            if (m_busy) busy_cycles++;
            if (prev_busy && !m_busy) busy_falls++;
            prev_busy = m_busy;
        end
        check("b2b busy cycles", busy_cycles, 2 * MFRM);
        check("b2b busy falls", busy_falls, 1);
        check("b2b decoded count", rx_q.size() - base, 2);
        if (rx_q.size() >= base + 2) begin
            check("b2b word0", rx_q[base], 8'hAC);
            check("b2b word1", rx_q[base + 1], 8'hCA);
        end

        // 5. Overflow table with tx_ready low, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            data_valid = tbl[i].dv; wr_en = tbl[i].we; data_in = tbl[i].data;
            cycle();
            check($sformatf("tbl%0d count", i), m_count, tbl[i].cnt);
            check($sformatf("tbl%0d full", i),  m_full,  tbl[i].full);
            check($sformatf("tbl%0d empty", i), m_empty, tbl[i].empty);
            check($sformatf("tbl%0d ovf", i),   m_ovf,   tbl[i].ovf);
        end
        data_valid = 1'b0; wr_en = 1'b0; tx_ready = 1'b1;
        base = rx_q.size();
        repeat (4 * MFRM + 10) cycle();
        check("drain decoded count", rx_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (rx_q.size() > base + i) check($sformatf("drain word%0d", i), rx_q[base + i], sent4[i]);
        check("drain count", m_count, 0);

        // 6a. tx_ready dropped mid-frame
        base = rx_q.size();
        data_valid = 1'b1; wr_en = 1'b1; data_in = 8'h5A;
        cycle();
        data_in = 8'h3C;
        cycle();
        data_valid = 1'b0; wr_en = 1'b0;
        repeat (10) cycle();
        tx_ready = 1'b0;
        repeat (60) cycle();
        check("flow decoded count", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("flow word", rx_q[base], 8'h5A);
        check("flow held count", m_count, 1);
        check("flow busy", m_busy, 1'b0);

        // 6b. Asynchronous reset during a start bit
        tx_ready = 1'b1;
        cycle();
        cycle();
        check("pre-reset line low", m_serial, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async reset serial_out", m_serial, 1'b1);
        check("async reset tx_busy", m_busy, 1'b0);
        repeat (2) @(negedge clk);
        model_reset();
        check("post-reset empty", m_empty, 1'b1);
        check("post-reset count", m_count, 0);
        rst_n = 1'b1;

        // 4. Parity and two stop bits on 0x07
        data_in = 8'h07; data_valid = 1'b1; wr_en = 1'b1;
        cycle();
        data_valid = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 12 * CPB; i++) begin
            cycle();
            check($sformatf("even line cyc%0d", i), e_serial, exp_even[i / CPB]);
            check($sformatf("odd line cyc%0d", i),  o_serial, exp_odd[i / CPB]);
            check($sformatf("even busy cyc%0d", i), e_busy, 1'b1);
            check($sformatf("odd busy cyc%0d", i),  o_busy, 1'b1);
        end
        cycle();
        check("even busy end", e_busy, 1'b0);
        check("odd busy end", o_busy, 1'b0);

        // Randomised traffic on u_main against the model
        rate = 20; rmode = 1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                rmode = $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0: rate = 2;
                    1: rate = 5;
                    2: rate = 30;
                    default: rate = 80;
                endcase
            end
            tx_ready   = (rmode == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
            data_valid = ($urandom_range(0, 99) < rate);
            wr_en      = ($urandom_range(0, 7) != 0);
            data_in    = 8'($urandom_range(0, 255));
            cycle();
        end
        data_valid = 1'b0; wr_en = 1'b0; tx_ready = 1'b1;
        repeat (MDEP * MFRM + 10) cycle();
        check("final drained empty", m_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_packetizer_param

// File: doc/uart_packetizer_param.md
# uart_packetizer_param

Parametrised successor to the fixed 8-bit UART packetizer: it buffers parallel words in an internal FIFO and serialises them as UART frames on `serial_out`, gated by a downstream `tx_ready`. Data width, FIFO depth, bit period, parity mode and stop-bit count are parameters. It adds FIFO occupancy and empty status, a dropped-write indication and back-to-back frame streaming. It sits between the byte-producing logic and the board UART pin.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of 2 and at least 2.
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); must be at least 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  DATA_W: word to enqueue.
- `data_valid`  in  1: `data_in` is valid this cycle.
- `wr_en`  in  1: write enable. A push occurs when `data_valid & wr_en & !fifo_full`.
- `tx_ready`  in  1: downstream permits a new frame. Sampled only at frame start.
- `serial_out`  out  1: UART line; idles high.
- `fifo_full`  out  1: FIFO holds FIFO_DEPTH entries.
- `fifo_empty`  out  1: FIFO holds 0 entries.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current occupancy.
- `tx_busy`  out  1: high from the first start-bit cycle to the last stop-bit cycle.
- `overflow`  out  1: one-cycle pulse when `data_valid & wr_en & fifo_full`; the word is dropped.

## Operation
- **FSM states:** IDLE, START, DATA, PAR, STOP. PAR is skipped when PARITY=0.
- **Launch:** IDLE → START when `!fifo_empty & tx_ready`.
  - The head word is popped on that edge and loaded into the shift register.
  - The baud counter loads CLKS_PER_BIT-1.
  - The parity bit is computed from the popped word at the same time.
- **Bit timing:** each state holds for CLKS_PER_BIT cycles. Bit index counts 0..DATA_W-1 in DATA.
- **Bit order:** data is sent LSB first.
  - Even parity sends the XOR of the data bits.
  - Odd parity sends its inverse.
- **Stop bits:** STOP drives 1 for STOP_BITS×CLKS_PER_BIT cycles.
- **End of STOP:**
  - If `!fifo_empty & tx_ready`, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- **`tx_ready` deasserted mid-frame:** the current frame completes; no new frame starts.
- **Frame length:** (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **FIFO pointers:** read and write pointers wrap modulo FIFO_DEPTH. `fifo_count` updates by +1 on push, −1 on pop, and is unchanged on a simultaneous push and pop.
- **Write while full:** rejected even if a pop occurs in the same cycle. `overflow` pulses and the count is unchanged.
- **Write while empty:** no fall-through. A word written in cycle N can launch no earlier than the edge after N+1.
- **Counter sizing:** the baud counter is $clog2(CLKS_PER_BIT) bits and the bit index is $clog2(DATA_W) bits. No arithmetic wraps beyond these limits.

## Timing
- **Reset values (`rst_n` low, asynchronous):**
  - `serial_out`=1, `tx_busy`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `overflow`=0, state=IDLE.
  - The FIFO contents are discarded.
- **Reset mid-frame:** `serial_out` returns to 1 immediately, without waiting for a clock edge.
- **Push:** `fifo_count` and the flags reflect a push on the edge after it is presented.
- **Launch latency:** if the launch condition is true in cycle N (IDLE), then from edge N+1:
  - `serial_out`=0 and `tx_busy`=1;
  - `fifo_count` decrements on the same edge.
- **`tx_busy` fall:** drops on the edge that ends the last stop bit, unless a back-to-back launch keeps it high.
- **Registered outputs:** all outputs are registered. `overflow` is registered from the rejected write cycle.

## Structure
- **Package `uart_pkg`:** FSM state enum, parity encodings (PAR_NONE/PAR_EVEN/PAR_ODD), idle line level constant.
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH. Ports: push, pop, din, dout, full, empty, count, async active-low reset. The top instantiates it and implements the FSM, baud counter and shift register.

## Test plan
Simulate with CLKS_PER_BIT=4.
1. **Reset:** hold `rst_n` low for 3 cycles → `serial_out`=1, `fifo_empty`=1, `fifo_count`=0, `tx_busy`=0.
2. **Single frame, default format (8N1):** push 0xAC with `tx_ready`=1 → line reads 0,0,0,1,1,0,1,0,1,1, each bit 4 cycles; `tx_busy` is high for 40 cycles; count returns to 0.
3. **Back-to-back frames:** push 0xAC then 0xCA with `tx_ready` held high → the second start bit immediately follows the first stop bit; `tx_busy` has no gap.
4. **Parity and stop bits:** PARITY=1, STOP_BITS=2, push 0x07 → parity bit=1; frame is 12 bits (48 cycles). Repeat with PARITY=2 → parity bit=0.
5. **Overflow with FIFO_DEPTH=4:**
   - Push 6 words with `tx_ready`=0 → `fifo_full`=1 after 4 pushes; `overflow` pulses twice; `fifo_count`=4.
   - Then raise `tx_ready` → exactly the first 4 words are sent, in order.
6. **Flow control and reset:**
   - Drop `tx_ready` mid-frame → that frame completes and no new start bit follows.
   - Assert `rst_n` low mid-frame → `serial_out`=1 asynchronously; the FIFO is empty after reset.
